// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side slice.
package fifo_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  // Cycles from rd to valid data_out on the FIFO.
  localparam int unsigned RD_LAT = 1;

  // Holding-buffer depth; RD_LAT slots of it are reserved for words already in flight.
  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_buf.sv
// Two-entry in-order holding buffer; head is always the oldest held word.
module fifo_rd_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = $bits(data_t)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        cnt
);

  logic [DATA_W-1:0] e0_q, e1_q;
  logic [1:0]        cnt_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= push_data;
          else               e1_q <= push_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains after the pop.
          if (cnt_q == 2'd2) begin
            e0_q <= e1_q;
            e1_q <= push_data;
          end else begin
            e0_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = e0_q;
  assign cnt  = cnt_q;

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clock) disable iff (!rst)
    !(push && !pop && cnt_q == 2'(BUF_DEPTH)));
  a_no_underflow : assert property (@(posedge clock) disable iff (!rst)
    !(pop && cnt_q == 2'd0));
`endif

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller: drains the FIFO and re-presents words on a valid/ready stream.
// Optional beat counter on word_cnt when FIFO_RD_STATS_EN is defined.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = $bits(data_t),
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              enable,
  input  logic              empty,
  input  logic [DATA_W-1:0] data_out,
  output logic              rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              idle
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_W-1:0]  word_cnt
`endif
);

  localparam int unsigned CreditMax = BUF_DEPTH - RD_LAT;

  logic       run_q;
  logic       infl_q;
  logic       pop;
  logic [1:0] cnt;
  logic [2:0] load;

  // run_q keeps rd low while reset is asserted and for the first edge after release.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      run_q  <= 1'b0;
      infl_q <= 1'b0;
    end else begin
      run_q  <= 1'b1;
      infl_q <= rd;
    end
  end

  assign pop  = out_valid & out_ready;
  assign load = {1'b0, cnt} + {2'b00, infl_q};

  // A pop this cycle frees a slot, so out_ready feeds rd combinationally.
  assign rd = run_q & enable & ~empty & (load <= (3'(CreditMax) + {2'b00, pop}));

  fifo_rd_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clock     (clock),
    .rst       (rst),
    .push      (infl_q),
    .push_data (data_out),
    .pop       (pop),
    .head      (out_data),
    .cnt       (cnt)
  );

  assign out_valid = (cnt != 2'd0);
  assign idle      = (cnt == 2'd0) & ~infl_q & empty;

`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] word_cnt_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst)     word_cnt_q <= '0;
    else if (pop) word_cnt_q <= word_cnt_q + CNT_W'(1);
  end

  assign word_cnt = word_cnt_q;
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural 1-cycle-latency FIFO model.
// Define FIFO_RD_STATS_EN to also check the beat counter (CNT_W=4).
module tb_fifo_reader;

`ifdef FIFO_RD_STATS_EN
  localparam int unsigned TbCntW = 4;
`else
  localparam int unsigned TbCntW = 16;
`endif

  logic       clock = 1'b0;
  logic       rst;
  logic       enable;
  logic       empty;
  logic [7:0] data_out;
  logic       rd;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       idle;
`ifdef FIFO_RD_STATS_EN
  logic [TbCntW-1:0] word_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fifo_reader #(
    .DATA_W (8),
    .CNT_W  (TbCntW)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .enable    (enable),
    .empty     (empty),
    .data_out  (data_out),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .idle      (idle)
`ifdef FIFO_RD_STATS_EN
    ,
    .word_cnt  (word_cnt)
`endif
  );

  // FIFO model: writes from the stimulus process, reads on rd with one cycle of latency.
  logic [7:0] mem [64];
  int wptr = 0;
  int rptr = 0;

  assign empty = (rptr == wptr);

  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      rptr     <= wptr;
      data_out <= 8'h00;
    end else if (rd) begin
      total = total + 1;
      if (empty) begin
        bad = bad + 1;
        $display("FAIL rd_while_empty: rd=1 with empty=1 at %0t", $time);
      end else begin
        data_out <= mem[rptr % 64];
        rptr     <= rptr + 1;
      end
    end
  end

  task automatic fifo_push(input logic [7:0] d);
    mem[wptr % 64] = d;
    wptr = wptr + 1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit         en;
    bit         rdy;
    bit         psh;
    logic [7:0] pd;
    bit         e_rd;
    bit         e_vld;
    logic [7:0] e_dat;
    bit         e_idle;
  } vec_t;

  function automatic vec_t mk(bit en, bit rdy, bit psh, logic [7:0] pd,
                              bit e_rd, bit e_vld, logic [7:0] e_dat, bit e_idle);
    vec_t v;
    v.en = en; v.rdy = rdy; v.psh = psh; v.pd = pd;
    v.e_rd = e_rd; v.e_vld = e_vld; v.e_dat = e_dat; v.e_idle = e_idle;
    return v;
  endfunction

  // One cycle: drive inputs just after the edge, check mid-cycle before the next edge.
  task automatic step(input vec_t v, input int idx);
    string tag;
    @(posedge clock);
    #1;
    enable    = v.en;
    out_ready = v.rdy;
    if (v.psh) fifo_push(v.pd);
    #3;
    tag = $sformatf("row%0d", idx);
    chk({tag, "_rd"}, 32'(rd), 32'(v.e_rd));
    chk({tag, "_valid"}, 32'(out_valid), 32'(v.e_vld));
    if (v.e_vld) chk({tag, "_data"}, 32'(out_data), 32'(v.e_dat));
    chk({tag, "_idle"}, 32'(idle), 32'(v.e_idle));
  endtask

  vec_t tbl[$];
  vec_t tbl_rst[$];

  initial begin
    int k;
    int gaps;

    rst       = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("reset_rd", 32'(rd), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_idle", 32'(idle), 32'd1);
`ifdef FIFO_RD_STATS_EN
    chk("reset_word_cnt", 32'(word_cnt), 32'd0);
`endif
    #11;
    rst = 1'b1;

    // Three words streamed back to back.
    tbl.push_back(mk(0, 1, 1, 8'h11, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 1, 8'h22, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 1, 8'h33, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 1, 1, 8'h11, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 8'h22, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 8'h33, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 1));
    // Empty FIFO with reads enabled.
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 1));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1));
    // Five words under back-pressure: two reads, stable head, then gap-free drain.
    tbl.push_back(mk(0, 0, 1, 8'ha1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 1, 8'ha2, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 1, 8'ha3, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 1, 8'ha4, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 1, 8'ha5, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 8'ha1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 8'ha1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 8'ha1, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 1, 1, 8'ha1, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 1, 1, 8'ha2, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 1, 1, 8'ha3, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 8'ha4, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 8'ha5, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 1));
    // enable dropped right after the first read; in-flight word still delivered.
    tbl.push_back(mk(0, 1, 1, 8'hb1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 1, 8'hb2, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 1, 8'hb3, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'hb1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 8'hb2, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 8'hb3, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 1));
    // Start of the reset sequence: one word goes in flight.
    tbl.push_back(mk(0, 1, 1, 8'hc1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 1, 8'hc2, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 1, 8'hc3, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 1, 0, 8'h00, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Async reset with 0xc1 in flight: outputs clear at once, word is dropped.
    @(posedge clock);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_rd", 32'(rd), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_idle", 32'(idle), 32'd1);
    @(posedge clock);
    @(posedge clock);
    #2;
    rst = 1'b1;

    tbl_rst.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 1));
    tbl_rst.push_back(mk(1, 1, 1, 8'hd1, 1, 0, 8'h00, 0));
    tbl_rst.push_back(mk(1, 1, 1, 8'hd2, 1, 0, 8'h00, 0));
    tbl_rst.push_back(mk(1, 1, 0, 8'h00, 0, 1, 8'hd1, 0));
    tbl_rst.push_back(mk(1, 1, 0, 8'h00, 0, 1, 8'hd2, 0));
    tbl_rst.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 1));
    for (int i = 0; i < tbl_rst.size(); i++) step(tbl_rst[i], 100 + i);

    // 18-word burst from a clean reset: in order, no bubbles once started.
    @(posedge clock);
    #1;
    enable = 1'b0;
    rst    = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 18; i++) fifo_push(8'(8'h40 + i));
    enable    = 1'b1;
    out_ready = 1'b1;
    k    = 0;
    gaps = 0;
    for (int c = 0; c < 60 && k < 18; c++) begin
      @(posedge clock);
      #4;
      if (out_valid) begin
        chk($sformatf("burst_data%0d", k), 32'(out_data), 32'(8'h40 + k));
        k++;
      end else if (k > 0) begin
        gaps++;
      end
    end
    chk("burst_count", 32'(k), 32'd18);
    chk("burst_gaps", 32'(gaps), 32'd0);
    @(posedge clock);
    #4;
    chk("burst_idle", 32'(idle), 32'd1);
`ifdef FIFO_RD_STATS_EN
    chk("word_cnt_wrap", 32'(word_cnt), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
Read-side controller for the team's synchronous FIFO: drains it via rd/empty/data_out and re-presents words downstream on a valid/ready stream. Handles the FIFO's 1-cycle read latency with a 2-entry holding buffer, sustaining 1 word/cycle without ever reading an empty FIFO. Sits between the FIFO's data_out and any consumer (e.g. a serializer or a checker).

Parameters:
DATA_W, 8, width of FIFO word and out_data
CNT_W, 16, width of the stats counter (used only with FIFO_RD_STATS_EN)

Ports:
clock  in  1  single clock, rising edge
rst  in  1  asynchronous active-low reset (asserted when 0)
enable  in  1  1 = allowed to issue new FIFO reads
empty  in  1  FIFO empty flag
data_out  in  DATA_W  FIFO read data, valid exactly 1 cycle after rd
rd  out  1  FIFO read strobe
out_valid  out  1  downstream word available
out_ready  in  1  downstream accepts word
out_data  out  DATA_W  downstream word
idle  out  1  no held words, none in flight, FIFO empty
word_cnt  out  CNT_W  accepted-beat count (present only with FIFO_RD_STATS_EN)

Behaviour:
- Reset (rst=0, async): rd=0, out_valid=0, out_data=0, held count=0, in-flight=0, word_cnt=0; idle then follows empty. Any in-flight word is discarded.
- State: held count cnt in {0,1,2}, 1-bit in-flight flag infl (rd issued last cycle).
- pop = out_valid & out_ready.
- rd = enable & ~empty & (cnt + infl - pop <= 1); combinational (path out_ready->rd is intentional). rd never asserted while empty=1.
- Capture: when infl=1, data_out is written into the buffer that cycle; infl <= rd.
- Buffer is in-order 2-entry; out_valid = (cnt != 0); out_data = oldest held word.
- Simultaneous capture+pop: cnt unchanged, order preserved. Capture without pop: cnt+1. Pop without capture: cnt-1.
- Credit rule guarantees cnt never exceeds 2; capture into a full buffer cannot occur (assertion in RTL, sim-only).
- Stall: while out_valid=1 and out_ready=0, out_data and out_valid hold stable.
- Throughput: with enable=1, out_ready=1 and FIFO non-empty, one rd per cycle; first out_valid 2 cycles after first rd... i.e. rd at T, word captured at T+1, out_valid at T+2.
- enable deassert: no new rd; in-flight word is still captured; held words continue to drain.
- idle = (cnt==0) & ~infl & empty.

Optional Feature:
FIFO_RD_STATS_EN
- Defined: word_cnt port present; increments by 1 on every pop, wraps at 2^CNT_W; cleared by reset.
- Undefined: word_cnt port and counter absent; all other behaviour identical.

Decomposition:
- Package fifo_pkg: DATA_W default constant (8), typedef data_t = logic [DATA_W-1:0], constant RD_LAT = 1.
- One sub-module: fifo_rd_buf (2-entry in-order holding buffer with push/pop/cnt); fifo_reader holds credit logic, infl flag and stats counter.

Test Plan:
- Writer pushes 0x11,0x22,0x33; enable=1, out_ready=1 -> rd high 3 consecutive cycles, out_data 0x11,0x22,0x33 on consecutive cycles from 2 cycles after first rd; idle=1 after.
- FIFO holds 5 words, out_ready=0 -> exactly 2 rd pulses, out_valid=1 stable with first word; raise out_ready -> all 5 delivered in order, no gaps.
- FIFO empty throughout, enable=1 -> rd never asserted, out_valid=0, idle=1.
- enable=0 one cycle after first rd -> in-flight word still delivered, no further rd; re-enable -> reads resume, order intact.
- Async rst=0 mid-stream with 1 word in flight -> outputs zero immediately, in-flight word dropped; after release, reader resumes from FIFO's post-reset state.
- With FIFO_RD_STATS_EN, CNT_W=4, 18 words accepted -> word_cnt = 2 (wrap).
